// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the timeout counter sizing helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } lsu_state_e;

    function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response channel and data-memory bus of the LSU.
// The LSU is the slave of the core channel and the master of the memory bus.
interface lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, byte strobes, store-lane
// replication and load shift/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        err,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        illegal    = 1'b0;
        misaligned = 1'b0;
        wstrb      = '0;
        wdata_lane = '0;
        rdata_ext  = '0;
        shifted    = rdata >> {addr_lo, 3'b000};

        case (func3)
            F3_B: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                misaligned = addr_lo[0];
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                misaligned = |addr_lo;
                wstrb      = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = shifted;
            end
            F3_BU: begin
                illegal   = we;
                rdata_ext = {24'b0, shifted[7:0]};
            end
            F3_HU: begin
                illegal    = we;
                misaligned = addr_lo[0];
                rdata_ext  = {16'b0, shifted[15:0]};
            end
            default: illegal = 1'b1;
        endcase

        // Loads never drive byte enables or write data onto the bus.
        if (!we) begin
            wstrb      = '0;
            wdata_lane = '0;
        end
        err = illegal | misaligned;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit top: request latch, bus FSM with registered outputs and a
// per-state timeout guard.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    lsu_core_if.slave     core,
    lsu_mem_if.master     mem
);

    localparam int unsigned       CNT_W    = tmo_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        idle;
    logic        a_err;
    logic [3:0]  a_wstrb;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        tmo;

    assign idle = (state_q == IDLE);
    assign tmo  = (cnt_q == CNT_LAST);

    // In IDLE the aligner checks the incoming request; afterwards it extends
    // load data using the latched fields.
    lsu_align u_align (
        .we         (idle ? core.req_we         : we_q),
        .func3      (idle ? core.req_func3      : func3_q),
        .addr_lo    (idle ? core.req_addr[1:0]  : addr_lo_q),
        .wdata      (core.req_wdata),
        .rdata      (mem.mem_rdata),
        .err        (a_err),
        .wstrb      (a_wstrb),
        .wdata_lane (a_wdata),
        .rdata_ext  (a_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        func3_d      = func3_q;
        addr_lo_d    = addr_lo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (core.req_valid) begin
                    we_d      = core.req_we;
                    func3_d   = core.req_func3;
                    addr_lo_d = core.req_addr[1:0];
                    if (a_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = MEM_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = core.req_we;
                        mem_addr_d  = {core.req_addr[31:2], 2'b00};
                        mem_wstrb_d = a_wstrb;
                        mem_wdata_d = a_wdata;
                    end
                end
            end
            MEM_REQ: begin
                if (mem.mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (we_q || mem.mem_rvalid) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? 32'h0 : a_rdata;
                    end else begin
                        state_d = MEM_WAIT;
                        cnt_d   = '0;
                    end
                end else if (tmo) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = a_rdata;
                end else if (tmo) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            func3_q      <= '0;
            addr_lo_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            func3_q      <= func3_d;
            addr_lo_q    <= addr_lo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign core.req_ready  = idle;
    assign core.busy       = !idle;
    assign core.resp_valid = resp_valid_q;
    assign core.resp_err   = resp_err_q;
    assign core.resp_rdata = resp_rdata_q;
    assign mem.mem_req     = mem_req_q;
    assign mem.mem_we      = mem_we_q;
    assign mem.mem_addr    = mem_addr_q;
    assign mem.mem_wstrb   = mem_wstrb_q;
    assign mem.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written
// timeout/reset sequences and random transactions against a byte-lane model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int unsigned TMO   = 16;
    localparam int          NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_core_if core ();
    lsu_mem_if  mem ();

    lsu_ctrl #(.TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core),
        .mem  (mem)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        logic        e_err;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        bit          req_seen;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          stable;
        logic        req_at_resp;
        logic        busy1;
        logic        ready1;
        logic        post_valid;
        logic        post_ready;
    } obs_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core.req_valid = 1'b0;
        core.req_we    = 1'b0;
        core.req_func3 = 3'b000;
        core.req_addr  = 32'h0;
        core.req_wdata = 32'h0;
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata  = 32'h0;
    endtask

    // Reference model: works on access size and byte lanes directly.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int gd, input int rd);
        exp_t        e;
        int          size;
        int          off;
        bit          uns;
        bit          bad;
        logic [31:0] val;
        size = 1; uns = 0; bad = 0;
        off  = int'(addr[1:0]);
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1; bad = we; end
            3'd5: begin size = 2; uns = 1; bad = we; end
            default: bad = 1;
        endcase
        if (off % size != 0) bad = 1;
        e.err = 0; e.wstrb = '0; e.wdata = '0; e.rdata = '0;
        if (bad) begin
            e.err = 1;
            e.lat = 1;
            return e;
        end
        if (gd >= int'(TMO)) begin
            e.err = 1; e.lat = int'(TMO) + 1;
        end else if (we || rd == 0) begin
            e.lat = gd + 2;
        end else if (rd > int'(TMO)) begin
            e.err = 1; e.lat = gd + 2 + int'(TMO);
        end else begin
            e.lat = gd + 2 + rd;
        end
        if (we) begin
            for (int i = 0; i < size; i++) e.wstrb[off + i] = 1'b1;
            for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = wdata[8*(j % size) +: 8];
        end else if (!e.err) begin
            val = '0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = rdata[8*(off + i) +: 8];
            if (!uns && size < 4 && val[8*size - 1])
                for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
            e.rdata = val;
        end
        return e;
    endfunction

    // Drives one request and acts as the memory: grant after gd cycles of
    // mem_req, read data rd cycles after the grant (0 = same cycle).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gd, input int rd, output obs_t o);
        int k;
        int w;
        bit granted;
        o.lat = -1; o.err = 1'bx; o.rdata = 'x; o.req_seen = 0; o.we = 1'b0;
        o.addr = '0; o.wstrb = '0; o.wdata = '0; o.stable = 1; o.req_at_resp = 1'bx;
        o.busy1 = 1'bx; o.ready1 = 1'bx;
        k = 0; w = 0; granted = 0;
        core.req_valid = 1'b1;
        core.req_we    = we;
        core.req_func3 = f3;
        core.req_addr  = addr;
        core.req_wdata = wdata;
        tick();
        core.req_valid = 1'b0;
        core.req_wdata = ~wdata;
        for (int c = 1; c <= 64; c++) begin
            mem.mem_gnt    = 1'b0;
            mem.mem_rvalid = 1'b0;
            mem.mem_rdata  = ~rdata;
            if (c == 1) begin
                o.busy1  = core.busy;
                o.ready1 = core.req_ready;
            end
            if (core.resp_valid) begin
                o.lat         = c;
                o.err         = core.resp_err;
                o.rdata       = core.resp_rdata;
                o.req_at_resp = mem.mem_req;
                break;
            end
            if (mem.mem_req) begin
                if (!o.req_seen) begin
                    o.req_seen = 1;
                    o.we    = mem.mem_we;
                    o.addr  = mem.mem_addr;
                    o.wstrb = mem.mem_wstrb;
                    o.wdata = mem.mem_wdata;
                end else if (mem.mem_we !== o.we || mem.mem_addr !== o.addr ||
                             mem.mem_wstrb !== o.wstrb || mem.mem_wdata !== o.wdata) begin
                    o.stable = 0;
                end
                if (granted) o.stable = 0;
                if (k == gd) begin
                    mem.mem_gnt = 1'b1;
                    granted     = 1;
                    if (!we && rd == 0) begin
                        mem.mem_rvalid = 1'b1;
                        mem.mem_rdata  = rdata;
                    end
                end
                k++;
            end else if (granted && !we) begin
                w++;
                if (w == rd) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = rdata;
                end
            end
            tick();
        end
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        tick();
        o.post_valid = core.resp_valid;
        o.post_ready = core.req_ready;
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [31:0] addr,
                             input exp_t e, input obs_t o);
        bit bus;
        bus = (e.lat > 1);
        check({tag, ".lat"},        o.lat, e.lat);
        check({tag, ".err"},        o.err, e.err);
        check({tag, ".rdata"},      o.rdata, e.rdata);
        check({tag, ".busy"},       o.busy1, 1'b1);
        check({tag, ".ready"},      o.ready1, 1'b0);
        check({tag, ".pulse"},      o.post_valid, 1'b0);
        check({tag, ".ready_after"}, o.post_ready, 1'b1);
        check({tag, ".req_seen"},   o.req_seen, bus);
        if (bus) begin
            check({tag, ".addr"},   o.addr, {addr[31:2], 2'b00});
            check({tag, ".we"},     o.we, we);
            check({tag, ".wstrb"},  o.wstrb, e.wstrb);
            check({tag, ".stable"}, o.stable, 1'b1);
            check({tag, ".req_drop"}, o.req_at_resp, 1'b0);
            if (we) check({tag, ".wdata"}, o.wdata, e.wdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[15];
    obs_t o;
    exp_t e;

    initial begin
        vecs[0]  = '{we:1'b0, f3:F3_B,   addr:32'h103, wdata:32'h0,        rdata:32'h80FF_1234, gd:0,     rd:0,
                     e_err:1'b0, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'hFFFF_FF80, e_lat:2};
        vecs[1]  = '{we:1'b1, f3:F3_H,   addr:32'h202, wdata:32'h0000_ABCD, rdata:32'h0,       gd:3,     rd:0,
                     e_err:1'b0, e_wstrb:4'hC, e_wdata:32'hABCD_ABCD, e_rdata:32'h0,        e_lat:5};
        vecs[2]  = '{we:1'b0, f3:F3_W,   addr:32'h301, wdata:32'h0,        rdata:32'h1111_1111, gd:0,     rd:0,
                     e_err:1'b1, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_lat:1};
        vecs[3]  = '{we:1'b0, f3:3'b011, addr:32'h400, wdata:32'h0,        rdata:32'h2222_2222, gd:0,     rd:0,
                     e_err:1'b1, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_lat:1};
        vecs[4]  = '{we:1'b1, f3:F3_B,   addr:32'h001, wdata:32'h1234_5678, rdata:32'h0,       gd:0,     rd:0,
                     e_err:1'b0, e_wstrb:4'h2, e_wdata:32'h7878_7878, e_rdata:32'h0,        e_lat:2};
        vecs[5]  = '{we:1'b1, f3:F3_W,   addr:32'h010, wdata:32'hDEAD_BEEF, rdata:32'h0,       gd:1,     rd:0,
                     e_err:1'b0, e_wstrb:4'hF, e_wdata:32'hDEAD_BEEF, e_rdata:32'h0,        e_lat:3};
        vecs[6]  = '{we:1'b0, f3:F3_HU,  addr:32'h00A, wdata:32'h0,        rdata:32'h8001_7FFE, gd:0,     rd:2,
                     e_err:1'b0, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0000_8001, e_lat:4};
        vecs[7]  = '{we:1'b0, f3:F3_H,   addr:32'h00A, wdata:32'h0,        rdata:32'h8001_7FFE, gd:1,     rd:1,
                     e_err:1'b0, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'hFFFF_8001, e_lat:4};
        vecs[8]  = '{we:1'b0, f3:F3_BU,  addr:32'h002, wdata:32'h0,        rdata:32'h00A5_0000, gd:0,     rd:0,
                     e_err:1'b0, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0000_00A5, e_lat:2};
        vecs[9]  = '{we:1'b1, f3:F3_H,   addr:32'h003, wdata:32'h5555_5555, rdata:32'h0,       gd:0,     rd:0,
                     e_err:1'b1, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_lat:1};
        vecs[10] = '{we:1'b1, f3:F3_BU,  addr:32'h000, wdata:32'h6666_6666, rdata:32'h0,       gd:0,     rd:0,
                     e_err:1'b1, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_lat:1};
        vecs[11] = '{we:1'b0, f3:F3_W,   addr:32'h020, wdata:32'h0,        rdata:32'hCAFE_F00D, gd:2,     rd:3,
                     e_err:1'b0, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'hCAFE_F00D, e_lat:7};
        vecs[12] = '{we:1'b0, f3:F3_W,   addr:32'h044, wdata:32'h0,        rdata:32'h7777_7777, gd:NEVER, rd:0,
                     e_err:1'b1, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_lat:17};
        vecs[13] = '{we:1'b1, f3:F3_B,   addr:32'h003, wdata:32'h0000_00E7, rdata:32'h0,       gd:2,     rd:0,
                     e_err:1'b0, e_wstrb:4'h8, e_wdata:32'hE7E7_E7E7, e_rdata:32'h0,        e_lat:4};
        vecs[14] = '{we:1'b0, f3:F3_B,   addr:32'h001, wdata:32'h0,        rdata:32'h0000_7F00, gd:0,     rd:1,
                     e_err:1'b0, e_wstrb:4'h0, e_wdata:32'h0,        e_rdata:32'h0000_007F, e_lat:3};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("reset.req_ready",  core.req_ready, 1'b1);
        check("reset.busy",       core.busy, 1'b0);
        check("reset.resp_valid", core.resp_valid, 1'b0);
        check("reset.resp_err",   core.resp_err, 1'b0);
        check("reset.resp_rdata", core.resp_rdata, 32'h0);
        check("reset.mem_req",    mem.mem_req, 1'b0);
        check("reset.mem_we",     mem.mem_we, 1'b0);
        check("reset.mem_addr",   mem.mem_addr, 32'h0);
        check("reset.mem_wstrb",  mem.mem_wstrb, 4'h0);
        check("reset.mem_wdata",  mem.mem_wdata, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].gd, vecs[i].rd, o);
            e.err = vecs[i].e_err; e.wstrb = vecs[i].e_wstrb; e.wdata = vecs[i].e_wdata;
            e.rdata = vecs[i].e_rdata; e.lat = vecs[i].e_lat;
            check_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, e, o);
        end

        // Load timeout in MEM_WAIT, then stale bus inputs, then normal traffic.
        run_txn(1'b0, F3_HU, 32'h40, 32'h0, 32'h1234_5678, 0, NEVER, o);
        e.err = 1'b1; e.wstrb = 4'h0; e.wdata = 32'h0; e.rdata = 32'h0; e.lat = 2 + int'(TMO);
        check_txn("tmo_wait", 1'b0, 32'h40, e, o);
        for (int i = 0; i < 3; i++) begin
            mem.mem_rvalid = 1'b1;
            mem.mem_gnt    = 1'b1;
            mem.mem_rdata  = 32'hBAD0_0000 + 32'(i);
            tick();
            check($sformatf("stale%0d.resp_valid", i), core.resp_valid, 1'b0);
            check($sformatf("stale%0d.busy", i), core.busy, 1'b0);
            check($sformatf("stale%0d.mem_req", i), mem.mem_req, 1'b0);
        end
        mem.mem_rvalid = 1'b0;
        mem.mem_gnt    = 1'b0;
        run_txn(1'b0, F3_W, 32'h80, 32'h0, 32'h0BAD_F00D, 1, 2, o);
        check_txn("after_tmo", 1'b0, 32'h80, model(1'b0, F3_W, 32'h80, 32'h0, 32'h0BAD_F00D, 1, 2), o);

        // Reset while waiting for read data, then while still requesting.
        for (int pass = 0; pass < 2; pass++) begin
            core.req_valid = 1'b1;
            core.req_we    = 1'b0;
            core.req_func3 = F3_W;
            core.req_addr  = 32'h50;
            tick();
            core.req_valid = 1'b0;
            if (pass == 0) begin
                mem.mem_gnt = 1'b1;
                tick();
                mem.mem_gnt = 1'b0;
                tick();
            end
            check($sformatf("rst%0d.busy_before", pass), core.busy, 1'b1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check($sformatf("rst%0d.req_ready", pass), core.req_ready, 1'b1);
            check($sformatf("rst%0d.mem_req", pass), mem.mem_req, 1'b0);
            check($sformatf("rst%0d.resp_valid", pass), core.resp_valid, 1'b0);
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata  = 32'h5A5A_5A5A;
            for (int i = 0; i < 3; i++) begin
                tick();
                check($sformatf("rst%0d.quiet%0d", pass, i), core.resp_valid, 1'b0);
            end
            mem.mem_rvalid = 1'b0;
        end

        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [31:0] rdv;
            int          gd;
            int          rd;
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            wd   = $urandom;
            rdv  = $urandom;
            gd   = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 3));
            rd   = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 4));
            run_txn(we, f3, addr, wd, rdv, gd, rd, o);
            check_txn($sformatf("rnd%0d", n), we, addr, model(we, f3, addr, wd, rdv, gd, rd), o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
